uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, the companion to the existing UART_TX transmitter. Recovers 8N1 frames (start bit, 8 data bits LSB-first, one stop bit) from the asynchronous rx_serial line. Uses an oversampling tick from the shared baud generator. Presents each received byte in a one-entry holding register with valid/read handshake, and flags framing and overrun errors.

Parameters:
DATA_BITS, 8, data bits per frame (LSB first)
OVERSAMPLE, 16, os_tick pulses per bit period; must be even and at least 4

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset (low = reset)
os_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate
rx_serial  input  1  asynchronous serial line; idle high
rx_read  input  1  consumer pulse; clears rx_valid
rx_data  output  DATA_BITS  last good received byte
rx_valid  output  1  level; rx_data holds an unread byte
rx_done  output  1  one-clk pulse per good frame
frame_err  output  1  one-clk pulse when stop bit is sampled low
overrun  output  1  one-clk pulse when an unread byte is overwritten

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; tick_cnt, bit_cnt and shift register cleared.
  - rx_data = 0; rx_valid, rx_done, frame_err and overrun = 0.
  - Synchronizer flops = 1.
- Reset is honoured mid-frame. After release, the receiver hunts for a fresh falling edge; the partial byte is lost.
- rx_serial passes through a 2-flop synchronizer (rx_sync) before any use; this adds 2 clk of latency. All sampling below uses rx_sync.
- State and counters advance only on clk edges where os_tick = 1. Exceptions: rx_read handling, and pulse clearing, which happen on every clk.
- IDLE: if os_tick and rx_sync = 0, go to START with tick_cnt = 0.
- START: on each os_tick, tick_cnt increments. When tick_cnt = OVERSAMPLE/2-1 (mid start bit):
  - rx_sync = 0: go to DATA with tick_cnt = 0 and bit_cnt = 0.
  - rx_sync = 1: glitch; return to IDLE with no output activity.
- DATA:
  - On each os_tick, tick_cnt increments. At tick_cnt = OVERSAMPLE-1 (mid-bit), sample rx_sync into the shift register MSB with a right shift (LSB-first), clear tick_cnt, and increment bit_cnt.
  - After the DATA_BITS-th sample, go to STOP.
- STOP: at tick_cnt = OVERSAMPLE-1, sample the stop bit and return to IDLE.
  - Stop = 1:
    - rx_data <= shift register; rx_valid <= 1; rx_done pulses for 1 clk.
    - If rx_valid was already 1 and rx_read is not asserted this cycle, overrun pulses for 1 clk. The new byte replaces the old one.
  - Stop = 0: frame_err pulses for 1 clk; rx_data and rx_valid are unchanged.
  - A line held low (break) re-triggers START and yields one frame_err per frame time.
- Sampling point: every sample falls at mid-bit. The first data sample occurs 1.5 bit periods after the detected start edge.
- rx_read:
  - Clears rx_valid on the next clk.
  - If rx_read coincides with a good-frame load, the load wins: rx_valid stays 1 with the new byte and no overrun is flagged.
  - rx_read while rx_valid = 0 has no effect.
- Output timing: all outputs are registered. rx_done, frame_err and overrun are never high for more than one clk.
- Width rules: bit_cnt is wide enough to hold DATA_BITS, and tick_cnt is wide enough to hold OVERSAMPLE-1. Both use $clog2 sizing; no wrap-around is reachable in legal operation.

Decomposition:
- Shared package uart_pkg holds:
  - frame state encodings IDLE/START/DATA/STOP as 2'd0..2'd3, shared with UART_TX;
  - defaults DATA_BITS = 8 and OVERSAMPLE = 16.
- One sub-module, uart_sync2: a 2-flop synchronizer with parameterised reset value 1, reset by the active-low rst. It is reusable for other asynchronous inputs.

Test Plan:
- All tests use os_tick = 1 every clk and OVERSAMPLE = 16, so one bit = 16 clk.
- Reset then idle line high for 100 clk -> all outputs 0; state stays IDLE.
- Send 0xA5 with good stop -> rx_data = 0xA5, rx_valid = 1, one rx_done pulse, no error pulses. rx_read then clears rx_valid 1 clk later.
- Low glitch of 4 clk on an idle line -> no rx_done and no frame_err; the next valid frame 0x5A is received correctly.
- Send 0x3C with stop bit = 0 -> one frame_err pulse; rx_valid stays 0; rx_data unchanged.
- Send 0x11 then 0x22 back-to-back without rx_read -> one overrun pulse at 0x22's stop, with rx_data = 0x22. Repeating with rx_read on the same clk as the second load -> no overrun.
- Assert rst low mid-way through byte 0x0F (bit 4), release, then send 0xF0 -> outputs cleared during reset; only 0xF0 is received, with one rx_done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and default frame geometry.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

  // Frame state encoding, common to the transmitter and the receiver.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Default frame geometry: 8 data bits, 16 oversampling ticks per bit.
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Latency: 2 clk from async_i to sync_o.
// Backpressure: none; it samples every clk.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Resolve metastability over two stages; reset to the idle level of the line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// UART 8N1 receiver with oversampled mid-bit sampling and a one-entry holding register.
// Latency: rx_done rises 2 clk (synchronizer) + 1 clk after the mid stop-bit sample tick.
// Backpressure: none; an unread byte is overwritten by the next good frame and flagged.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE   // must be even and >= 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 os_tick,
  input  logic                 rx_serial,
  input  logic                 rx_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 overrun
);

  // tick_cnt must reach OVERSAMPLE-1; bit_cnt must reach DATA_BITS.
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rx_sync;

  uart_state_e          state_q;
  logic [TW-1:0]        tick_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;

  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 rx_done_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  logic [TW-1:0]        tick_cnt_d;
  logic [BW-1:0]        bit_cnt_d;
  logic [DATA_BITS-1:0] shift_d;
  logic                 tick_at_mid;
  logic                 tick_at_last;

  // The serial line is asynchronous; nothing downstream looks at it directly.
  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (rx_serial),
    .sync_o  (rx_sync)
  );

  // Next-value helpers: counter increments and the LSB-first right shift.
  always_comb begin
    tick_cnt_d   = tick_cnt_q + TICK_ONE;
    bit_cnt_d    = bit_cnt_q + BIT_ONE;
    shift_d      = {rx_sync, shift_q[DATA_BITS-1:1]};
    tick_at_mid  = (tick_cnt_q == TICK_MID);
    tick_at_last = (tick_cnt_q == TICK_LAST);
  end

  // Frame FSM plus holding register and status pulses, all registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // Pulses last a single clk regardless of os_tick.
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // A read clears the holding register; a same-cycle load below overrides it.
      if (rx_read) begin
        rx_valid_q <= 1'b0;
      end

      if (os_tick) begin
        case (state_q)
          IDLE: begin
            // Falling edge on the line: candidate start bit.
            if (!rx_sync) begin
              state_q    <= START;
              tick_cnt_q <= '0;
            end
          end

          START: begin
            if (tick_at_mid) begin
              tick_cnt_q <= '0;
              if (!rx_sync) begin
                // Still low at mid start bit: a real frame.
                state_q   <= DATA;
                bit_cnt_q <= '0;
              end else begin
                // Line recovered: a glitch, drop it silently.
                state_q <= IDLE;
              end
            end else begin
              tick_cnt_q <= tick_cnt_d;
            end
          end

          DATA: begin
            // One full bit period after the previous mid point is the next mid point.
            if (tick_at_last) begin
              shift_q    <= shift_d;
              tick_cnt_q <= '0;
              bit_cnt_q  <= bit_cnt_d;
              if (bit_cnt_q == BIT_LAST) begin
                state_q <= STOP;
              end
            end else begin
              tick_cnt_q <= tick_cnt_d;
            end
          end

          STOP: begin
            if (tick_at_last) begin
              state_q    <= IDLE;
              tick_cnt_q <= '0;
              if (rx_sync) begin
                // Good frame: load wins over a coincident read.
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
                rx_done_q  <= 1'b1;
                overrun_q  <= rx_valid_q & ~rx_read;
              end else begin
                // Bad stop bit: keep the previous byte untouched.
                frame_err_q <= 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_d;
            end
          end

          default: begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames in, received bytes scoreboarded.
module tb_uart_rx;
  import uart_pkg::*;

  logic       clk;
  logic       rst;
  logic       os_tick;
  logic       rx_serial;
  logic       rx_read;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_done;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  // Observed pulse counts and the bench's own expected counts.
  int n_done = 0, n_ferr = 0, n_ovr = 0;
  int exp_done = 0, exp_ferr = 0, exp_ovr = 0;
  logic [7:0] ovr_data = 8'h00;
  logic prev_done = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;

  logic [7:0] exp_q[$];

  uart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .os_tick   (os_tick),
    .rx_serial (rx_serial),
    .rx_read   (rx_read),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: counts pulses, checks pulse width, pops scoreboard on rx_done.
  always @(negedge clk) begin
    if (rx_done) begin
      n_done++;
      chk("rx_done_width", 32'(prev_done), 32'd0);
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_unexpected_byte: observed=0x%0h expected=none", rx_data);
      end
      if (exp_q.size() != 0) begin
        chk("sb_rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
    if (frame_err) begin
      n_ferr++;
      chk("frame_err_width", 32'(prev_ferr), 32'd0);
    end
    if (overrun) begin
      n_ovr++;
      ovr_data = rx_data;
      chk("overrun_width", 32'(prev_ovr), 32'd0);
    end
    prev_done = rx_done;
    prev_ferr = frame_err;
    prev_ovr  = overrun;
  end

  // Hold the line at v for n clk; changes land 1 time unit after a rising edge.
  task automatic drive_bit(input logic v, input int n);
    rx_serial = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(b[i], 16);
    drive_bit(stop, 16);
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_q.push_back(b);
    exp_done++;
    send_byte(b, 1'b1);
  endtask

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_pulse();
    @(negedge clk) rx_read = 1'b1;
    @(negedge clk) rx_read = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    os_tick   = 1'b1;
    rx_serial = 1'b1;
    rx_read   = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_rx_valid",  32'(rx_valid),  32'd0);
    chk("rst_rx_data",   32'(rx_data),   32'd0);
    chk("rst_rx_done",   32'(rx_done),   32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun",   32'(overrun),   32'd0);
    rst = 1'b1;

    // Idle line for 100 clk.
    idle(100);
    @(negedge clk);
    chk("idle_state",   32'(dut.state_q), 32'(IDLE));
    chk("idle_valid",   32'(rx_valid),    32'd0);
    chk("idle_n_done",  32'(n_done),      32'(exp_done));
    chk("idle_n_ferr",  32'(n_ferr),      32'(exp_ferr));

    // Good frame 0xA5, then read.
    send_good(8'hA5);
    idle(10);
    @(negedge clk);
    chk("a5_data",   32'(rx_data),  32'h0A5);
    chk("a5_valid",  32'(rx_valid), 32'd1);
    chk("a5_n_done", 32'(n_done),   32'(exp_done));
    chk("a5_n_ferr", 32'(n_ferr),   32'(exp_ferr));
    chk("a5_n_ovr",  32'(n_ovr),    32'(exp_ovr));
    read_pulse();
    chk("a5_read_clears", 32'(rx_valid), 32'd0);

    // 4-clk low glitch, then a real frame 0x5A.
    @(posedge clk);
    #1;
    drive_bit(1'b0, 4);
    idle(40);
    chk("glitch_n_done", 32'(n_done), 32'(exp_done));
    chk("glitch_n_ferr", 32'(n_ferr), 32'(exp_ferr));
    chk("glitch_state",  32'(dut.state_q), 32'(IDLE));
    send_good(8'h5A);
    idle(10);
    chk("5a_data",   32'(rx_data), 32'h05A);
    chk("5a_n_done", 32'(n_done),  32'(exp_done));
    read_pulse();

    // 0x3C with a low stop bit.
    exp_ferr++;
    send_byte(8'h3C, 1'b0);
    idle(40);
    chk("fe_n_ferr", 32'(n_ferr),   32'(exp_ferr));
    chk("fe_valid",  32'(rx_valid), 32'd0);
    chk("fe_data",   32'(rx_data),  32'h05A);
    chk("fe_n_done", 32'(n_done),   32'(exp_done));

    // Back-to-back 0x11, 0x22 with no read: overrun on the second.
    exp_ovr++;
    send_good(8'h11);
    send_good(8'h22);
    idle(10);
    chk("ovr_n_ovr",  32'(n_ovr),    32'(exp_ovr));
    chk("ovr_data",   32'(ovr_data), 32'h022);
    chk("ovr_rx_data",32'(rx_data),  32'h022);
    chk("ovr_n_done", 32'(n_done),   32'(exp_done));
    read_pulse();

    // Same pair, read coinciding with the second load (stop sample at edge 155).
    send_good(8'h11);
    exp_q.push_back(8'h22);
    exp_done++;
    fork
      send_byte(8'h22, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        @(negedge clk) rx_read = 1'b1;
        @(negedge clk) rx_read = 1'b0;
      end
    join
    idle(10);
    chk("rdload_n_ovr", 32'(n_ovr),    32'(exp_ovr));
    chk("rdload_valid", 32'(rx_valid), 32'd1);
    chk("rdload_data",  32'(rx_data),  32'h022);

    // Reset in the middle of 0x0F (during bit 4), then 0xF0.
    @(posedge clk);
    #1;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
    rx_serial = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    rx_serial = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(rx_valid),     32'd0);
    chk("mid_rst_data",  32'(rx_data),      32'd0);
    chk("mid_rst_state", 32'(dut.state_q),  32'(IDLE));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(40);
    send_good(8'hF0);
    idle(10);
    chk("f0_data",   32'(rx_data),  32'h0F0);
    chk("f0_valid",  32'(rx_valid), 32'd1);
    chk("f0_n_done", 32'(n_done),   32'(exp_done));
    chk("f0_n_ferr", 32'(n_ferr),   32'(exp_ferr));
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx
